// File: rtl/bocks_pkg.sv
// Shared definitions for the framebuffer read-back path.
//   PIXEL_WIDTH/HEIGHT/COUNT : framebuffer geometry (1 byte per pixel)
//   FB_BYTE_COUNT            : number of packed upload bytes (8 pixels each)
//   FB_ADDR_W                : framebuffer pixel address width
//   THRESHOLD                : pixel value at or above which the packed bit is 1
//   fb_rb_state_t            : fb_readback control states
package bocks_pkg;

    localparam int PIXEL_WIDTH   = 640;
    localparam int PIXEL_HEIGHT  = 480;
    localparam int PIXEL_COUNT   = PIXEL_WIDTH * PIXEL_HEIGHT;
    localparam int FB_BYTE_COUNT = PIXEL_COUNT / 8;
    localparam int FB_ADDR_W     = 32;
    localparam int BYTE_IDX_W    = 16;    // holds 0..FB_BYTE_COUNT inclusive

    localparam logic [7:0]            THRESHOLD       = 8'h80;
    localparam logic [BYTE_IDX_W-1:0] FB_BYTE_COUNT_B = BYTE_IDX_W'(FB_BYTE_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fb_rb_state_t;

    // First pixel address of packed byte n (8*n, zero-extended, never wraps
    // because n is range-checked before use).
    function automatic logic [FB_ADDR_W-1:0] byte_to_pixel_addr(input logic [BYTE_IDX_W-1:0] n);
        return {{(FB_ADDR_W - BYTE_IDX_W - 3){1'b0}}, n, 3'b000};
    endfunction

endpackage

// File: rtl/fb_readback_packer.sv
// fb_byte_packer: thresholds incoming pixels to one bit and shifts them into
// an 8-bit accumulator at the LSB, so the first pixel ends up in bit 7.
//   pclk, reset : clock, synchronous active-high reset
//   clear       : restart accumulation (wins over shift_en)
//   shift_en    : pixel is valid this cycle
//   pixel       : framebuffer pixel value
//   result      : accumulator including the current pixel (combinational)
//   done        : this cycle's pixel is the 8th since clear
module fb_byte_packer
    import bocks_pkg::*;
(
    input  logic       pclk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [7:0] pixel,
    output logic [7:0] result,
    output logic       done
);

    logic [7:0] acc_reg;
    logic [2:0] cnt_reg;
    logic       pix_bit;

    assign pix_bit = (pixel >= THRESHOLD);
    // Exposing the byte with the current pixel already merged lets the owner
    // commit it on the same edge the last pixel arrives.
    assign result  = {acc_reg[6:0], pix_bit};
    assign done    = shift_en && !clear && (cnt_reg == 3'd7);

    always_ff @(posedge pclk) begin
        if (reset || clear) begin
            acc_reg <= 8'h00;
            cnt_reg <= 3'd0;
        end else if (shift_en) begin
            acc_reg <= result;
            cnt_reg <= cnt_reg + 3'd1;
        end
    end

endmodule

// File: rtl/fb_readback.sv
// fb_readback: services ioctl upload reads by fetching 8 consecutive
// framebuffer pixels for upload byte N and packing them MSB first.
//   pclk, reset   : clock, synchronous active-high reset
//   ioctl_upload  : upload in progress (dropping it aborts a fetch)
//   ioctl_rd      : one-cycle read request for byte ioctl_addr
//   ioctl_addr    : upload byte address
//   ioctl_din     : packed byte, held until the next completed request
//   ioctl_wait    : high while a requested byte is being assembled
//   fb_rd_en      : framebuffer read strobe
//   fb_rd_addr    : framebuffer pixel address
//   fb_rd_data    : pixel, valid the cycle after fb_rd_en
// Optional feature macro FB_READBACK_PREFETCH_EN: after delivering byte N the
// block speculatively fetches N+1 so a sequential request can be answered
// without asserting ioctl_wait.
module fb_readback
    import bocks_pkg::*;
(
    input  logic        pclk,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [26:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        fb_rd_en,
    output logic [31:0] fb_rd_addr,
    input  logic [7:0]  fb_rd_data
);

    fb_rb_state_t          state_reg, state_next;
    logic [BYTE_IDX_W-1:0] byte_reg, byte_next;
    logic [2:0]            k_reg, k_next;
    logic [7:0]            din_reg, din_next;
    logic                  wait_reg, wait_next;
    logic                  rd_en_reg, rd_en_next;
    logic [FB_ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
    logic                  data_valid_reg;

    logic                  req_valid, addr_ok;
    logic [BYTE_IDX_W-1:0] req_byte;
    logic                  start_fetch;
    logic [BYTE_IDX_W-1:0] start_byte;
    logic                  pk_clear, pk_done;
    logic [7:0]            pk_result;

    assign req_valid = ioctl_rd && ioctl_upload;
    assign addr_ok   = (ioctl_addr < 27'(FB_BYTE_COUNT));
    assign req_byte  = ioctl_addr[BYTE_IDX_W-1:0];

    // Clearing on the first fetch cycle also discards any pixel still in
    // flight from an aborted or discarded fetch.
    assign pk_clear  = (state_reg == FETCH) && (k_reg == 3'd0);

`ifdef FB_READBACK_PREFETCH_EN
    logic                  spec_reg, spec_next;      // current fetch is speculative
    logic                  pend_reg, pend_next;      // host waits on the speculative fetch
    logic                  pf_valid_reg, pf_valid_next;
    logic [7:0]            pf_data_reg, pf_data_next;
    logic [BYTE_IDX_W-1:0] chain_byte;
    logic                  chain_ok, req_match;

    assign chain_byte = byte_reg + 16'd1;
    assign chain_ok   = (chain_byte < FB_BYTE_COUNT_B);
    // byte_reg names the speculative/prefetched byte whenever one exists.
    assign req_match  = req_valid && addr_ok && (req_byte == byte_reg);
`endif

    fb_byte_packer u_packer (
        .pclk     (pclk),
        .reset    (reset),
        .clear    (pk_clear),
        .shift_en (data_valid_reg),
        .pixel    (fb_rd_data),
        .result   (pk_result),
        .done     (pk_done)
    );

    always_comb begin
        state_next   = state_reg;
        byte_next    = byte_reg;
        k_next       = k_reg;
        din_next     = din_reg;
        wait_next    = wait_reg;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr_reg;
        start_fetch  = 1'b0;
        start_byte   = req_byte;
`ifdef FB_READBACK_PREFETCH_EN
        spec_next     = spec_reg;
        pend_next     = pend_reg;
        pf_valid_next = pf_valid_reg;
        pf_data_next  = pf_data_reg;
`endif
        unique case (state_reg)
            IDLE: begin
`ifdef FB_READBACK_PREFETCH_EN
                if (!ioctl_upload) begin
                    pf_valid_next = 1'b0;
                end
                if (req_valid) begin
                    pf_valid_next = 1'b0;
                    if (pf_valid_reg && req_match) begin
                        din_next = pf_data_reg;
                        if (chain_ok) begin
                            start_fetch = 1'b1;
                            start_byte  = chain_byte;
                            spec_next   = 1'b1;
                        end
                    end else if (addr_ok) begin
                        start_fetch = 1'b1;
                        spec_next   = 1'b0;
                        wait_next   = 1'b1;
                    end else begin
                        din_next = 8'h00;
                    end
                end
`else
                if (req_valid) begin
                    if (addr_ok) begin
                        start_fetch = 1'b1;
                        wait_next   = 1'b1;
                    end else begin
                        din_next = 8'h00;
                    end
                end
`endif
            end
            FETCH: begin
                k_next = k_reg + 3'd1;
                if (k_reg == 3'd7) begin
                    state_next = DRAIN;
                end else begin
                    rd_en_next   = 1'b1;
                    rd_addr_next = rd_addr_reg + 32'd1;
                end
            end
            DRAIN: begin
                state_next = IDLE;
                wait_next  = 1'b0;
`ifdef FB_READBACK_PREFETCH_EN
                spec_next  = 1'b0;
                pend_next  = 1'b0;
                if (pk_done) begin
                    if (!spec_reg || pend_reg || req_match) begin
                        din_next = pk_result;
                        if (chain_ok) begin
                            start_fetch = 1'b1;
                            start_byte  = chain_byte;
                            spec_next   = 1'b1;
                        end
                    end else begin
                        pf_data_next  = pk_result;
                        pf_valid_next = 1'b1;
                    end
                end
`else
                if (pk_done) begin
                    din_next = pk_result;
                end
`endif
            end
            default: state_next = IDLE;
        endcase

        if (state_reg != IDLE) begin
            if (!ioctl_upload) begin
                // Abort: back to IDLE, keep the last delivered byte.
                start_fetch = 1'b0;
                state_next  = IDLE;
                rd_en_next  = 1'b0;
                wait_next   = 1'b0;
                din_next    = din_reg;
`ifdef FB_READBACK_PREFETCH_EN
                spec_next     = 1'b0;
                pend_next     = 1'b0;
                pf_valid_next = 1'b0;
                pf_data_next  = pf_data_reg;
`endif
            end
`ifdef FB_READBACK_PREFETCH_EN
            else if (spec_reg && !pend_reg && req_valid && !req_match) begin
                // Host wants something else: drop the speculative fetch.
                pf_valid_next = 1'b0;
                pf_data_next  = pf_data_reg;
                pend_next     = 1'b0;
                spec_next     = 1'b0;
                if (addr_ok) begin
                    start_fetch = 1'b1;
                    start_byte  = req_byte;
                    wait_next   = 1'b1;
                    din_next    = din_reg;
                end else begin
                    start_fetch = 1'b0;
                    state_next  = IDLE;
                    rd_en_next  = 1'b0;
                    wait_next   = 1'b0;
                    din_next    = 8'h00;
                end
            end else if (spec_reg && !pend_reg && req_valid && (state_reg == FETCH)) begin
                pend_next = 1'b1;
                wait_next = 1'b1;
            end
`endif
        end

        if (start_fetch) begin
            state_next   = FETCH;
            byte_next    = start_byte;
            k_next       = 3'd0;
            rd_en_next   = 1'b1;
            rd_addr_next = byte_to_pixel_addr(start_byte);
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg      <= IDLE;
            byte_reg       <= '0;
            k_reg          <= 3'd0;
            din_reg        <= 8'h00;
            wait_reg       <= 1'b0;
            rd_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_reg       <= byte_next;
            k_reg          <= k_next;
            din_reg        <= din_next;
            wait_reg       <= wait_next;
            rd_en_reg      <= rd_en_next;
            rd_addr_reg    <= rd_addr_next;
            data_valid_reg <= rd_en_reg;
        end
    end

`ifdef FB_READBACK_PREFETCH_EN
    always_ff @(posedge pclk) begin
        if (reset) begin
            spec_reg     <= 1'b0;
            pend_reg     <= 1'b0;
            pf_valid_reg <= 1'b0;
            pf_data_reg  <= 8'h00;
        end else begin
            spec_reg     <= spec_next;
            pend_reg     <= pend_next;
            pf_valid_reg <= pf_valid_next;
            pf_data_reg  <= pf_data_next;
        end
    end
`endif

    assign ioctl_din  = din_reg;
    assign ioctl_wait = wait_reg;
    assign fb_rd_en   = rd_en_reg;
    assign fb_rd_addr = rd_addr_reg;

endmodule

// File: tb/tb_fb_readback.sv
// Self-checking bench for fb_readback: directed vector table, hand-written
// multi-cycle sequences and randomized requests against a pixel-level model.
// Honours FB_READBACK_PREFETCH_EN for the timing-dependent expectations.
module tb_fb_readback;

    localparam int NPIX  = 307200;
    localparam int NBYTE = 38400;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [26:0] ioctl_addr = 27'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        fb_rd_en;
    logic [31:0] fb_rd_addr;
    logic [7:0]  fb_rd_data = 8'h00;

    fb_readback dut (
        .pclk         (pclk),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .fb_rd_en     (fb_rd_en),
        .fb_rd_addr   (fb_rd_addr),
        .fb_rd_data   (fb_rd_data)
    );

    always #5 pclk = ~pclk;

    // Framebuffer RAM with one-cycle registered read.
    logic [7:0] fb_mem [0:NPIX-1];
    always @(posedge pclk) begin
        if (fb_rd_en)
            fb_rd_data <= (fb_rd_addr < NPIX) ? fb_mem[fb_rd_addr[18:0]] : 8'h00;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: byte n is the 8 pixels 8n..8n+7 thresholded at 0x80, first pixel MSB.
    function automatic logic [7:0] model_byte(input int n);
        int b;
        b = 0;
        if (n < 0 || n >= NBYTE) return 8'h00;
        for (int i = 0; i < 8; i++)
            b = b * 2 + ((fb_mem[8 * n + i] >= 8'h80) ? 1 : 0);
        return 8'(b);
    endfunction

    task automatic set_px(input int base, input logic [63:0] px);
        for (int i = 0; i < 8; i++)
            fb_mem[base + i] = px[63 - 8 * i -: 8];
    endtask

    // Per-cycle schedule relative to request cycle T (index 0), and history.
    logic        s_rd   [0:47];
    logic [26:0] s_addr [0:47];
    logic        s_up   [0:47];
    logic        h_wait [0:47];
    logic        h_en   [0:47];
    logic [31:0] h_addr [0:47];
    logic [7:0]  h_din  [0:47];

    task automatic clear_sched();
        for (int j = 0; j < 48; j++) begin
            s_rd[j] = 1'b0; s_addr[j] = 27'd0; s_up[j] = 1'b1;
        end
    endtask

    task automatic run_window(input int n);
        for (int j = 0; j <= n; j++) begin
            @(posedge pclk); #1;
            ioctl_rd = s_rd[j]; ioctl_addr = s_addr[j]; ioctl_upload = s_up[j];
            @(negedge pclk);
            h_wait[j] = ioctl_wait; h_en[j] = fb_rd_en;
            h_addr[j] = fb_rd_addr; h_din[j] = ioctl_din;
        end
        @(posedge pclk); #1;
        ioctl_rd = 1'b0; ioctl_upload = 1'b1;
    endtask

    function automatic int count_wait(input int a, input int b);
        int c = 0;
        for (int j = a; j <= b; j++) c += int'(h_wait[j]);
        return c;
    endfunction

    function automatic int count_en(input int a, input int b);
        int c = 0;
        for (int j = a; j <= b; j++) c += int'(h_en[j]);
        return c;
    endfunction

    typedef struct {
        logic [26:0] addr;
        logic [7:0]  exp_din;
        bit          in_range;
    } vec_t;
    vec_t vecs [0:6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad, n, prev, gap;
        logic [7:0] exp;

        for (int i = 0; i < NPIX; i++) fb_mem[i] = 8'($urandom);
        set_px(0,      64'h80808080_80808080);
        set_px(8,      64'hFF00FF00_807F00FF);
        set_px(16,     64'h7F7F7F7F_7F7F7F7F);
        set_px(24,     64'h80808080_00000000);
        set_px(307192, 64'h00810081_00810081);

        vecs[0] = '{27'd1,      8'hA9, 1'b1};
        vecs[1] = '{27'd3,      8'hF0, 1'b1};
        vecs[2] = '{27'd0,      8'hFF, 1'b1};
        vecs[3] = '{27'd2,      8'h00, 1'b1};
        vecs[4] = '{27'd38399,  8'h55, 1'b1};
        vecs[5] = '{27'd38400,  8'h00, 1'b0};
        vecs[6] = '{27'd100000, 8'h00, 1'b0};

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset_din",  ioctl_din, 0);
        check("reset_wait", ioctl_wait, 0);
        check("reset_en",   fb_rd_en, 0);
        check("reset_addr", fb_rd_addr, 0);
        @(posedge pclk); #1;
        reset = 1'b0; ioctl_upload = 1'b1;

        // Directed vector table
        for (int v = 0; v < 7; v++) begin
            clear_sched();
            s_rd[0] = 1'b1; s_addr[0] = vecs[v].addr;
            run_window(14);
            if (vecs[v].in_range) begin
                bad = 0;
                for (int j = 1; j <= 8; j++)
                    if (h_addr[j] !== 32'(8 * int'(vecs[v].addr) + j - 1)) bad++;
                check("vec_wait_T1_T9", count_wait(1, 9), 9);
                check("vec_wait_T10",   h_wait[10], 0);
                check("vec_en_T1_T8",   count_en(1, 8), 8);
                check("vec_en_T9",      h_en[9], 0);
                check("vec_addr_seq",   bad, 0);
                check("vec_din_T10",    h_din[10], vecs[v].exp_din);
            end else begin
                check("oor_din_T1", h_din[1], 8'h00);
                check("oor_wait",   count_wait(1, 14), 0);
                check("oor_en",     count_en(1, 14), 0);
            end
            $display("vec addr=%0d din=%02h", vecs[v].addr, h_din[10]);
        end

        // Reset held 3 cycles in the middle of a fetch
        clear_sched(); s_rd[0] = 1'b1; s_addr[0] = 27'd1;
        run_window(12);
        check("pre_reset_din", h_din[12], 8'hA9);
        @(posedge pclk); #1; ioctl_rd = 1'b1; ioctl_addr = 27'd3;
        @(posedge pclk); #1; ioctl_rd = 1'b0;
        repeat (2) @(posedge pclk);
        #1; reset = 1'b1;
        @(negedge pclk);
        check("mid_reset_wait_before", ioctl_wait, 1);
        repeat (3) @(posedge pclk);
        #1; reset = 1'b0;
        @(negedge pclk);
        check("mid_reset_din",  ioctl_din, 0);
        check("mid_reset_wait", ioctl_wait, 0);
        check("mid_reset_en",   fb_rd_en, 0);
        check("mid_reset_addr", fb_rd_addr, 0);
        $display("reset mid-traffic din=%02h wait=%0b", ioctl_din, ioctl_wait);

        // Upload dropped at T+4
        clear_sched(); s_rd[0] = 1'b1; s_addr[0] = 27'd3;
        run_window(12);
        clear_sched(); s_rd[0] = 1'b1; s_addr[0] = 27'd1;
        s_up[4] = 1'b0; s_up[5] = 1'b0; s_up[6] = 1'b0;
        run_window(14);
        check("abort_wait_T4",  h_wait[4], 1);
        check("abort_wait_T5",  h_wait[5], 0);
        check("abort_en_T5",    h_en[5], 0);
        check("abort_en_after", count_en(5, 14), 0);
        check("abort_din_keep", h_din[12], 8'hF0);
        $display("abort addr=1 din=%02h", h_din[12]);
        clear_sched(); s_rd[0] = 1'b1; s_addr[0] = 27'd1;
        run_window(12);
        check("after_abort_din",  h_din[10], 8'hA9);
        check("after_abort_wait", h_wait[10], 0);

        // Second request at T+3 ignored
        clear_sched(); s_rd[0] = 1'b1; s_addr[0] = 27'd0;
        s_rd[3] = 1'b1; s_addr[3] = 27'd5;
        run_window(14);
        bad = 0;
        for (int j = 1; j <= 14; j++)
            if (h_en[j] && h_addr[j] >= 32'd40 && h_addr[j] <= 32'd47) bad++;
        check("dup_no_reads", bad, 0);
        check("dup_din_T10",  h_din[10], 8'hFF);
        check("dup_wait_T10", h_wait[10], 0);
        $display("dup rd addr=0 din=%02h", h_din[10]);

        // Sequential rd 0 then rd 1 at T+20, then rd 5
        clear_sched(); s_rd[0] = 1'b1; s_addr[0] = 27'd0;
        s_rd[20] = 1'b1; s_addr[20] = 27'd1;
        run_window(32);
        check("seq_din0_T10", h_din[10], model_byte(0));
`ifdef FB_READBACK_PREFETCH_EN
        check("pf_en_T10",   h_en[10], 1);
        check("pf_addr_T10", h_addr[10], 32'd8);
        check("pf_din_T21",  h_din[21], model_byte(1));
        check("pf_no_wait",  count_wait(20, 32), 0);
`else
        check("seq_en_T10",   h_en[10], 0);
        check("seq_wait1",    count_wait(21, 29), 9);
        check("seq_din_T29",  h_din[29], model_byte(0));
        check("seq_din1_T30", h_din[30], model_byte(1));
`endif
        $display("seq rd 0,1 din=%02h", h_din[32]);
        clear_sched(); s_rd[0] = 1'b1; s_addr[0] = 27'd5;
        run_window(12);
        check("seq5_wait",   count_wait(1, 9), 9);
        check("seq5_wait10", h_wait[10], 0);
        check("seq5_din",    h_din[10], model_byte(5));
        $display("seq rd 5 din=%02h", h_din[10]);

        // Randomized requests
        prev = 0;
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                6, 7:    n = prev + 1;
                8:       n = int'($urandom_range(38400, 134217727));
                9:       n = 38399;
                default: n = int'($urandom_range(0, 38399));
            endcase
            gap = int'($urandom_range(0, 12));
            repeat (gap) @(posedge pclk);
            @(posedge pclk); #1; ioctl_rd = 1'b1; ioctl_addr = 27'(n);
            @(posedge pclk); #1; ioctl_rd = 1'b0;
            lat = 0;
            for (int j = 1; j <= 40; j++) begin
                @(negedge pclk);
                if (!ioctl_wait) begin
                    lat = j;
                    break;
                end
            end
            if (lat == 0) begin
                check("rand_timeout", 32'd1, 32'd0);
            end else begin
                exp = model_byte(n);
`ifdef FB_READBACK_PREFETCH_EN
                check("rand_lat_le10", (lat <= 10) ? 1 : 0, 1);
`else
                check("rand_lat", lat, (n < NBYTE) ? 10 : 1);
`endif
                check("rand_din", ioctl_din, exp);
            end
            $display("rand addr=%0d din=%02h exp=%02h lat=%0d", n, ioctl_din, exp, lat);
            prev = n;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
